// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants for the system ID / info slave.
//   - word offsets of the register map
//   - CAPS field positions
//   - CTRL bit that clears the uptime counter
//   - byte-lane mask helper for partial writes
package sysid_pkg;

  localparam int OFF_ID        = 0;
  localparam int OFF_TIMESTAMP = 1;
  localparam int OFF_CAPS      = 2;
  localparam int OFF_SCRATCH   = 3;
  localparam int OFF_UPTIME_LO = 4;
  localparam int OFF_UPTIME_HI = 5;
  localparam int OFF_CTRL      = 6;
  localparam int OFF_IRQ_MASK  = 7;
  localparam int OFF_STICKY    = 8;  // STICKY[i] lives at OFF_STICKY + i

  localparam int CAPS_VER_LSB  = 16;
  localparam int CAPS_NCH_LSB  = 8;
  localparam int CAPS_UPW_LSB  = 0;

  localparam int CTRL_CLR_BIT  = 0;

  // Expand 4 byte-enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: free-running uptime counter, wraps at all-ones.
//   clock    : system clock
//   reset    : async active-high reset, counter -> 0
//   clr_i    : synchronous clear, wins over the increment
//   value_o  : current count
module sysid_uptime_counter #(
  parameter int UPTIME_W = 48
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr_i,
  output logic [UPTIME_W-1:0] value_o
);

  logic [UPTIME_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + UPTIME_W'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/sysid_info_slave.sv
// sysid_info_slave: Avalon-MM slave exposing system ID, build timestamp,
// capabilities, scratch, uptime (atomic LO/HI pair) and NUM_CH sticky
// status channels with a masked interrupt.
//   clock, reset        : system clock, async active-high reset
//   address/read/write  : Avalon-MM word address and strobes (no waitrequest)
//   writedata/byteenable: write data and byte lanes
//   readdata            : registered read data, held between reads
//   readdatavalid       : one cycle after read
//   ch_status           : NUM_CH x 32 level status inputs, channel i at [32i+:32]
//   irq                 : registered OR of masked non-zero sticky channels
module sysid_info_slave
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [15:0] VERSION   = 16'h0001,
  parameter int          NUM_CH    = 4,
  parameter int          UPTIME_W  = 48,
  parameter int          ADDR_W    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  output logic                     readdatavalid,
  input  logic [NUM_CH*32-1:0]     ch_status,
  output logic                     irq
);

  localparam logic [31:0] CAPS_WORD =
    (32'(VERSION)        << CAPS_VER_LSB) |
    (32'(8'(NUM_CH))     << CAPS_NCH_LSB) |
    (32'(8'(UPTIME_W))   << CAPS_UPW_LSB);

  logic [31:0]                  addr_w;
  logic [31:0]                  wmask;
  logic [31:0]                  scratch_q, scratch_d;
  logic [NUM_CH-1:0]            irq_mask_q, irq_mask_d;
  logic [NUM_CH-1:0][31:0]      sticky_q, sticky_d;
  logic [NUM_CH-1:0]            irq_hit;
  logic [UPTIME_W-33:0]         shadow_q, shadow_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         rvld_q;
  logic                         irq_q;
  logic [UPTIME_W-1:0]          uptime;
  logic                         uptime_clr;
  logic [31:0]                  rd_word;

  assign addr_w = 32'(address);
  assign wmask  = be_mask(byteenable);

  // ---------------- uptime ----------------
  assign uptime_clr = write && (addr_w == OFF_CTRL) && byteenable[0]
                      && writedata[CTRL_CLR_BIT];

  sysid_uptime_counter #(.UPTIME_W(UPTIME_W)) u_uptime (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (uptime_clr),
    .value_o (uptime)
  );

  // Reading LO snapshots the upper bits so a following HI read is
  // coherent with it. Uses the pre-clear count on a coincident clear.
  always_comb begin
    shadow_d = shadow_q;
    if (read && (addr_w == OFF_UPTIME_LO)) shadow_d = uptime[UPTIME_W-1:32];
  end

  // ---------------- writable registers ----------------
  always_comb begin
    scratch_d  = scratch_q;
    irq_mask_d = irq_mask_q;
    if (write && (addr_w == OFF_SCRATCH))
      scratch_d = (scratch_q & ~wmask) | (writedata & wmask);
    // NUM_CH <= 8, so the whole mask lives in byte lane 0.
    if (write && (addr_w == OFF_IRQ_MASK) && byteenable[0])
      irq_mask_d = writedata[NUM_CH-1:0];
  end

  // ---------------- sticky channels ----------------
  // OR-ing the live status after the clear makes a same-cycle set win.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [31:0] clr;
    assign clr         = (write && (addr_w == 32'(OFF_STICKY + i))) ? (writedata & wmask) : '0;
    assign sticky_d[i] = (sticky_q[i] & ~clr) | ch_status[32*i +: 32];
    assign irq_hit[i]  = irq_mask_q[i] & (|sticky_q[i]);
  end

  // ---------------- read mux ----------------
  // All sources are pre-write register values, so a read colliding with
  // a write to the same offset returns the old contents.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (addr_w == 32'(OFF_STICKY + i)) rd_word = sticky_q[i];
    case (addr_w)
      OFF_ID:        rd_word = ID;
      OFF_TIMESTAMP: rd_word = TIMESTAMP;
      OFF_CAPS:      rd_word = CAPS_WORD;
      OFF_SCRATCH:   rd_word = scratch_q;
      OFF_UPTIME_LO: rd_word = uptime[31:0];
      OFF_UPTIME_HI: rd_word[UPTIME_W-33:0] = shadow_q;
      OFF_IRQ_MASK:  rd_word[NUM_CH-1:0]    = irq_mask_q;
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (read) rdata_d = rd_word;
  end

  // ---------------- state ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q  <= '0;
      irq_mask_q <= '0;
      sticky_q   <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      irq_mask_q <= irq_mask_d;
      sticky_q   <= sticky_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      rvld_q     <= read;
      irq_q      <= |irq_hit;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvld_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_sysid_info_slave.sv
module tb_sysid_info_slave;

  localparam int NUM_CH = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         address = '0;
  logic               read = 1'b0;
  logic               write = 1'b0;
  logic [31:0]        writedata = '0;
  logic [3:0]         byteenable = '0;
  logic [31:0]        readdata;
  logic               readdatavalid;
  logic [NUM_CH*32-1:0] ch_status = '0;
  logic               irq;

  int n_cmp = 0;
  int n_err = 0;

  sysid_info_slave #(
    .ID(32'h5BC449FF), .TIMESTAMP(32'h6543_2100), .VERSION(16'h0002),
    .NUM_CH(NUM_CH), .UPTIME_W(48), .ADDR_W(4)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .ch_status(ch_status), .irq(irq)
  );

  always #5 clock = ~clock;

  // Called at a negedge; read is seen at the next posedge, result sampled
  // at the following negedge.
  task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    d = readdata; v = readdatavalid;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d; logic v;
    rd(a, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== exp) begin
      n_err++;
      $display("FAIL %s: got data=%h valid=%b, want data=%h valid=1", nm, d, v, exp);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (readdata !== 32'h0 || readdatavalid !== 1'b0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%h rdv=%b irq=%b, want 0/0/0", readdata, readdatavalid, irq);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_id_regs;
    chk_rd("id", 4'd0, 32'h5BC449FF);
    chk_rd("timestamp", 4'd1, 32'h6543_2100);
    chk_rd("caps", 4'd2, 32'h0002_0430);
    // one idle cycle: valid drops, data holds
    @(negedge clock);
    n_cmp++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0002_0430) begin
      n_err++;
      $display("FAIL rdata_hold: got rd=%h rdv=%b, want 00020430/0", readdata, readdatavalid);
    end
    chk_rd("ctrl_reads_0", 4'd6, 32'h0);
  endtask

  task automatic test_scratch;
    chk_rd("scratch_reset", 4'd3, 32'h0);
    wr(4'd3, 32'hDEADBEEF, 4'b0101);
    chk_rd("scratch_be", 4'd3, 32'h00AD00EF);
    wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    chk_rd("unmapped", 4'd15, 32'h0);
  endtask

  task automatic test_rw_collision;
    address = 4'd3; writedata = 32'h1111_1111; byteenable = 4'hF;
    write = 1'b1; read = 1'b1;
    @(negedge clock);
    write = 1'b0; read = 1'b0;
    n_cmp++;
    if (readdata !== 32'h00AD00EF || readdatavalid !== 1'b1) begin
      n_err++;
      $display("FAIL rw_same_cycle: got rd=%h rdv=%b, want 00ad00ef/1", readdata, readdatavalid);
    end
    chk_rd("rw_after", 4'd3, 32'h1111_1111);
  endtask

  task automatic test_uptime_atomic;
    force dut.u_uptime.cnt_q = 48'h0001_FFFF_FFFE;
    #1 release dut.u_uptime.cnt_q;
    chk_rd("lo_a", 4'd4, 32'hFFFF_FFFE);   // latches hi=1
    @(negedge clock);                        // counter crosses into hi=2
    chk_rd("hi_a_latched", 4'd5, 32'h0000_0001);
    chk_rd("lo_b", 4'd4, 32'h0000_0001);   // counter now 2_0000_0001
    chk_rd("hi_b", 4'd5, 32'h0000_0002);
    force dut.u_uptime.cnt_q = 48'hFFFF_FFFF_FFFF;
    #1 release dut.u_uptime.cnt_q;
    chk_rd("lo_allones", 4'd4, 32'hFFFF_FFFF);
    chk_rd("lo_wrapped", 4'd4, 32'h0);
    chk_rd("hi_wrapped", 4'd5, 32'h0);
  endtask

  task automatic test_ctrl_clear;
    wr(4'd6, 32'h1, 4'b0001);               // cycle N
    chk_rd("clr_n1", 4'd4, 32'h0);          // N+1
    @(negedge clock);                        // N+2
    chk_rd("clr_n3", 4'd4, 32'h2);          // N+3
  endtask

  task automatic test_sticky_irq;
    wr(4'd7, 32'hFFFF_FFF2, 4'hF);
    chk_rd("irq_mask", 4'd7, 32'h2);
    ch_status[63:32] = 32'h10;
    @(negedge clock);
    ch_status = '0;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    @(negedge clock);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", irq); end
    chk_rd("sticky1", 4'd9, 32'h10);
    chk_rd("sticky0", 4'd8, 32'h0);
    wr(4'd9, 32'h10, 4'hF);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_lag: got %b want 1", irq); end
    @(negedge clock);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", irq); end
    chk_rd("sticky1_clr", 4'd9, 32'h0);
    // clear coincident with a new pulse: set wins
    ch_status[63:32] = 32'h10;
    wr(4'd9, 32'h10, 4'hF);
    ch_status = '0;
    chk_rd("set_wins", 4'd9, 32'h10);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    // lane 0 disabled: no clear
    wr(4'd9, 32'h10, 4'b1110);
    chk_rd("w1c_lane_off", 4'd9, 32'h10);
    wr(4'd9, 32'h10, 4'b0001);
    chk_rd("w1c_lane_on", 4'd9, 32'h0);
  endtask

  task automatic test_reset_mid_read;
    wr(4'd3, 32'h1234_5678, 4'hF);
    ch_status[31:0] = 32'h1;
    @(negedge clock);
    ch_status = '0;
    address = 4'd3; read = 1'b1;
    #2 reset = 1'b1;
    @(negedge clock);
    read = 1'b0;
    n_cmp++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got rd=%h rdv=%b irq=%b, want 0/0/0", readdata, readdatavalid, irq);
    end
    #1 reset = 1'b0;
    @(negedge clock);
    chk_rd("scratch_after_rst", 4'd3, 32'h0);
    chk_rd("sticky_after_rst", 4'd8, 32'h0);
    chk_rd("mask_after_rst", 4'd7, 32'h0);
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_scratch();
    test_rw_collision();
    test_uptime_atomic();
    test_ctrl_clear();
    test_sticky_irq();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, want finish before 100us");
    $fatal(1);
  end

endmodule

// File: doc/sysid_info_slave.md
Name: sysid_info_slave

Overview:
- Parametrised successor to the fixed single-word system ID slave: Avalon-MM slave on the Qsys interconnect exposing ID, build timestamp, version/capabilities, a scratch register, a free-running uptime counter with atomic 64-bit read, and NUM_CH sticky status channels with interrupt.
- Read by Nios II boot code and drivers to check hardware/software match and system health.

Parameters:
- ID, 32'h0000_0000, system ID word.
- TIMESTAMP, 32'h0000_0000, build timestamp word.
- VERSION, 16'h0001, block/system version.
- NUM_CH, 4, sticky status channels, legal 1..8.
- UPTIME_W, 48, uptime counter width, legal 33..64.
- ADDR_W, 4, word address width, must be >= 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  read data, registered.
- readdatavalid  out  1  high for one cycle, one clock after read.
- ch_status  in  NUM_CH*32  level status inputs, channel i at [32i+31:32i], synchronous to clock.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset: readdata=0, readdatavalid=0, irq=0, scratch=0, irq_mask=0, uptime=0, shadow_hi=0, all sticky=0.
- No waitrequest. Fixed read latency 1: read in cycle N gives readdatavalid=1 and readdata in N+1. readdata holds its last value when readdatavalid=0.
- Register map (word offsets):
  - 0 ID: RO.
  - 1 TIMESTAMP: RO.
  - 2 CAPS: RO, [31:16]=VERSION, [15:8]=NUM_CH, [7:0]=UPTIME_W.
  - 3 SCRATCH: RW, byteenable honoured.
  - 4 UPTIME_LO: RO, returns uptime[31:0]; the same read latches uptime[UPTIME_W-1:32] into shadow_hi.
  - 5 UPTIME_HI: RO, returns shadow_hi zero-extended to 32 bits.
  - 6 CTRL: write with bit0=1 (lane 0 enabled) clears uptime; reads 0.
  - 7 IRQ_MASK: RW, bits [NUM_CH-1:0]; upper bits read 0.
  - 8+i STICKY[i], i<NUM_CH: read returns sticky bits; write-1-to-clear per enabled byte lane.
  - All other offsets read 0; writes to them are ignored.
- Uptime: increments by 1 every clock and wraps from all-ones to 0. A CTRL clear write in cycle N gives uptime=0 in N+1, then counting resumes. A clear takes priority over the increment.
- Sticky update each cycle: sticky[i] <= (sticky[i] & ~clr_mask) | ch_status[i]. If set and clear hit the same bit in the same cycle, set wins.
- irq is registered: irq <= OR over i of (irq_mask[i] & |sticky[i]), one cycle behind sticky/mask.
- Read and write in the same cycle to the same offset: the write takes effect, and the read returns the pre-write value.
- UPTIME_LO read in the same cycle as a CTRL clear: returns and latches the pre-clear value.
- Reset asserted mid-transaction: all state returns to reset values immediately; a pending readdatavalid is dropped.

Decomposition:
- sysid_pkg holds register offset constants, CAPS field positions, and the CTRL clear bit index.
- Sub-module sysid_uptime_counter (UPTIME_W, clear, value out).
- Sticky/irq logic and the read mux stay in the top level.

Test Plan:
- Reset then read offsets 0,1,2 with ID=32'h5BC449FF, VERSION=16'h0002, NUM_CH=4, UPTIME_W=48 -> readdata 32'h5BC449FF, TIMESTAMP, 32'h0002_0430, each with readdatavalid exactly one cycle after read.
- Write SCRATCH 32'hDEADBEEF with byteenable=4'b0101 over the reset value 0 -> read returns 32'h00AD00EF. Read offset 15 -> 0.
- Force uptime near 2^32-1 (run about 2^32 cycles, or use a bench-only parameter UPTIME_W=33 and run 2^32-2 cycles), read LO then HI -> HI equals the value latched at the LO read even though the counter has since advanced. Wrap at all-ones -> 0.
- CTRL write 1 at cycle N -> an UPTIME_LO read at N+1 returns 0, and at N+3 returns 2.
- ch_status[1] pulses 32'h0000_0010 for one cycle with IRQ_MASK=4'b0010 -> STICKY[1]=32'h10 persists and irq rises two cycles after the pulse. Write 32'h10 to offset 9 -> sticky cleared and irq falls. Repeat with the clear write coincident with a new pulse -> bit stays set.
- Assert reset between read and readdatavalid -> readdatavalid stays 0, readdata=0, SCRATCH reads 0 afterwards.
